// File: rtl/slice_store_pkg.sv
// slice_store_pkg
// Shared definitions for the slice buffer and the permutation controller:
// state geometry (SIZE x SIZE lanes per slice, DEPTH slices) and the
// buffer's state encoding.
package slice_store_pkg;

   localparam int SS_SIZE    = 5;
   localparam int SS_MEMSIZE = SS_SIZE * SS_SIZE;
   localparam int SS_DEPTH   = 64;
   localparam int SS_AW      = $clog2(SS_DEPTH);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LOAD   = 2'd1,
      ST_SERVE  = 2'd2,
      ST_UNLOAD = 2'd3
   } state_e;

endpackage

// File: rtl/slice_store_ram.sv
// slice_ram
// DEPTH x MEMSIZE slice array.
//   wr_en_i/wr_addr_i/wr_data_i : single synchronous write port
//   rd_en_i/rd_addr_i/rd_data_o : registered read port (1-cycle latency,
//                                 holds its value when rd_en_i is low)
//   peek_addr_i/peek_data_o     : combinational read port
// The array itself is not reset; only the read register is.
module slice_ram #(
   parameter int DEPTH   = 64,
   parameter int MEMSIZE = 25,
   parameter int AW      = 6
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               wr_en_i,
   input  logic [AW-1:0]      wr_addr_i,
   input  logic [MEMSIZE-1:0] wr_data_i,
   input  logic               rd_en_i,
   input  logic [AW-1:0]      rd_addr_i,
   output logic [MEMSIZE-1:0] rd_data_o,
   input  logic [AW-1:0]      peek_addr_i,
   output logic [MEMSIZE-1:0] peek_data_o
);

   logic [MEMSIZE-1:0] mem_q [DEPTH];
   logic [MEMSIZE-1:0] rd_data_q;

   always_ff @(posedge clk) begin
      if (wr_en_i) begin
         mem_q[wr_addr_i] <= wr_data_i;
      end
   end

   // Reads sample the array before this edge's write lands, so a
   // same-address read and write returns the old slice.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_data_q <= '0;
      end else if (rd_en_i) begin
         rd_data_q <= mem_q[rd_addr_i];
      end
   end

   assign rd_data_o   = rd_data_q;
   assign peek_data_o = mem_q[peek_addr_i];

endmodule

// File: rtl/slice_store.sv
// slice_store
// Memory-side responder for the permutation controller. Loads DEPTH
// slices from an input stream, serves readLine requests with registered
// lines, absorbs DEPTH write-backs, then streams the result out.
//   start                 : begin a load (IDLE only)
//   inValid/inData/inReady: input stream (LOAD)
//   readLine/line/lineValid: controller reads (SERVE)
//   write/wrData          : controller write-backs (SERVE)
//   done                  : pulse on entering UNLOAD
//   outValid/outData/outReady: output stream (UNLOAD)
//   busy                  : not IDLE
module slice_store
   import slice_store_pkg::*;
#(
   parameter int SIZE    = SS_SIZE,
   parameter int MEMSIZE = SS_MEMSIZE,
   parameter int DEPTH   = SS_DEPTH,
   parameter int AW      = SS_AW
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               inValid,
   input  logic [MEMSIZE-1:0] inData,
   output logic               inReady,
   input  logic               readLine,
   output logic [MEMSIZE-1:0] line,
   output logic               lineValid,
   input  logic               write,
   input  logic [MEMSIZE-1:0] wrData,
   output logic               done,
   output logic               outValid,
   output logic [MEMSIZE-1:0] outData,
   input  logic               outReady,
   output logic               busy
);

   if ((MEMSIZE != SIZE * SIZE) || (DEPTH != (1 << AW))) begin : g_bad_cfg
      $error("slice_store: inconsistent geometry parameters");
   end

   localparam logic [AW:0] CNT_ONE = (AW + 1)'(1);

   state_e      state_q, state_d;
   // Each counter is AW+1 bits: the low AW bits address the array and the
   // MSB is the "DEPTH reached" flag, so no wrap-to-zero test is needed.
   logic [AW:0] wr_cnt_q, wr_cnt_d;
   logic [AW:0] rd_cnt_q, rd_cnt_d;
   logic [AW:0] wb_cnt_q, wb_cnt_d;
   logic [AW:0] u_cnt_q,  u_cnt_d;
   logic        line_valid_q, line_valid_d;
   logic        done_q, done_d;

   logic load_acc, rd_fire, wb_fire, out_fire;

   assign load_acc = (state_q == ST_LOAD)   && inValid;
   assign rd_fire  = (state_q == ST_SERVE)  && readLine && !rd_cnt_q[AW];
   assign wb_fire  = (state_q == ST_SERVE)  && write;
   assign out_fire = (state_q == ST_UNLOAD) && outReady;

   always_comb begin
      state_d      = state_q;
      wr_cnt_d     = wr_cnt_q;
      rd_cnt_d     = rd_cnt_q;
      wb_cnt_d     = wb_cnt_q;
      u_cnt_d      = u_cnt_q;
      line_valid_d = rd_fire;
      done_d       = 1'b0;

      if (state_q == ST_IDLE) begin
         wr_cnt_d = '0;
         rd_cnt_d = '0;
         wb_cnt_d = '0;
         u_cnt_d  = '0;
      end else begin
         if (load_acc) wr_cnt_d = wr_cnt_q + CNT_ONE;
         if (rd_fire)  rd_cnt_d = rd_cnt_q + CNT_ONE;
         if (wb_fire)  wb_cnt_d = wb_cnt_q + CNT_ONE;
         if (out_fire) u_cnt_d  = u_cnt_q  + CNT_ONE;
      end

      unique case (state_q)
         ST_IDLE: begin
            if (start) state_d = ST_LOAD;
         end
         ST_LOAD: begin
            if (load_acc && wr_cnt_d[AW]) state_d = ST_SERVE;
         end
         ST_SERVE: begin
            if (wb_fire && wb_cnt_d[AW]) begin
               state_d = ST_UNLOAD;
               done_d  = 1'b1;
            end
         end
         ST_UNLOAD: begin
            if (out_fire && u_cnt_d[AW]) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= ST_IDLE;
         wr_cnt_q     <= '0;
         rd_cnt_q     <= '0;
         wb_cnt_q     <= '0;
         u_cnt_q      <= '0;
         line_valid_q <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         wr_cnt_q     <= wr_cnt_d;
         rd_cnt_q     <= rd_cnt_d;
         wb_cnt_q     <= wb_cnt_d;
         u_cnt_q      <= u_cnt_d;
         line_valid_q <= line_valid_d;
         done_q       <= done_d;
      end
   end

   // Only one of LOAD/SERVE can be active, so the write port is a simple
   // state-selected mux.
   logic               ram_we;
   logic [AW-1:0]      ram_waddr;
   logic [MEMSIZE-1:0] ram_wdata;

   assign ram_we    = load_acc || wb_fire;
   assign ram_waddr = (state_q == ST_LOAD) ? wr_cnt_q[AW-1:0] : wb_cnt_q[AW-1:0];
   assign ram_wdata = (state_q == ST_LOAD) ? inData : wrData;

   slice_ram #(
      .DEPTH   (DEPTH),
      .MEMSIZE (MEMSIZE),
      .AW      (AW)
   ) u_ram (
      .clk         (clk),
      .rst         (rst),
      .wr_en_i     (ram_we),
      .wr_addr_i   (ram_waddr),
      .wr_data_i   (ram_wdata),
      .rd_en_i     (rd_fire),
      .rd_addr_i   (rd_cnt_q[AW-1:0]),
      .rd_data_o   (line),
      .peek_addr_i (u_cnt_q[AW-1:0]),
      .peek_data_o (outData)
   );

   assign inReady   = (state_q == ST_LOAD);
   assign outValid  = (state_q == ST_UNLOAD);
   assign busy      = (state_q != ST_IDLE);
   assign lineValid = line_valid_q;
   assign done      = done_q;

endmodule

// File: tb/tb_slice_store.sv
module tb_slice_store;
   import slice_store_pkg::*;

   localparam int MW = SS_MEMSIZE;
   localparam int D  = SS_DEPTH;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          start = 1'b0, inValid = 1'b0, readLine = 1'b0, write = 1'b0, outReady = 1'b0;
   logic [MW-1:0] inData = '0, wrData = '0;
   logic [MW-1:0] line, outData;
   logic          inReady, lineValid, done, outValid, busy;

   int n_assert = 0;
   int n_fail   = 0;

   // Reference: what the buffer should hold, and the last line returned.
   logic [MW-1:0] mem_m [D];
   logic [MW-1:0] exp_line = '0;

   always #5 clk = ~clk;

   slice_store dut (
      .clk(clk), .rst(rst), .start(start),
      .inValid(inValid), .inData(inData), .inReady(inReady),
      .readLine(readLine), .line(line), .lineValid(lineValid),
      .write(write), .wrData(wrData), .done(done),
      .outValid(outValid), .outData(outData), .outReady(outReady),
      .busy(busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_load(input logic [MW-1:0] mask);
      int i = 0;
      int guard = 0;
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("load_busy", busy, 1);
      while (i < D && guard < 1000) begin
         inValid  = ($urandom_range(0, 3) != 0);
         inData   = MW'(i) ^ mask;
         write    = $urandom_range(0, 1);   // must be ignored in LOAD
         wrData   = MW'($urandom);
         readLine = $urandom_range(0, 1);   // must be ignored in LOAD
         chk("load_inReady", inReady, 1);
         tick();
         if (inValid) begin
            mem_m[i] = inData;
            i++;
         end
         chk("load_lineValid", lineValid, 0);
         guard++;
      end
      inValid = 1'b0; write = 1'b0; readLine = 1'b0;
      chk("load_count", i, D);
      chk("load_inReady_drop", inReady, 0);
      chk("load_busy_after", busy, 1);
      $display("load mask=%h words=%0d cycles=%0d", mask, i, guard);
   endtask

   task automatic do_serve(input bit rand_wr);
      int  rd_i = 0;
      int  wb_i = 0;
      int  guard = 0;
      bit  first = 1'b1;
      bit  over_done = 1'b0;
      bit  rd, wr;
      while (wb_i < D && guard < 3000) begin
         if (first) begin
            rd = 1'b1; wr = 1'b1;
         end else begin
            rd = (rd_i < D) ? bit'($urandom_range(0, 1)) : (!over_done ? 1'b1 : bit'($urandom_range(0, 1)));
            wr = (wb_i < D - 1) ? bit'($urandom_range(0, 1)) : (rd_i >= D && over_done);
         end
         readLine = rd;
         write    = wr;
         wrData   = rand_wr ? MW'($urandom) : ~MW'(wb_i);
         if (first) wrData = 25'h1FFFFFF;
         // Model: read sees the array before this cycle's write-back.
         if (rd && rd_i < D) exp_line = mem_m[rd_i];
         if (rd && rd_i >= D) over_done = 1'b1;
         if (wr) mem_m[wb_i] = wrData;
         tick();
         chk(first ? "collision_lineValid" : "serve_lineValid", lineValid, (rd && rd_i < D));
         chk(first ? "collision_line" : "serve_line", line, exp_line);
         if (rd && rd_i < D) rd_i++;
         if (wr) wb_i++;
         chk("serve_done", done, (wr && wb_i == D));
         first = 1'b0;
         guard++;
      end
      readLine = 1'b0; write = 1'b0;
      chk("serve_writebacks", wb_i, D);
      chk("serve_overread_seen", over_done, 1);
      chk("unload_entry_outValid", outValid, 1);
      tick();
      chk("done_single_pulse", done, 0);
      $display("serve reads=%0d writebacks=%0d cycles=%0d", rd_i, wb_i, guard);
   endtask

   task automatic do_unload();
      int u = 0;
      int cyc = 0;
      bit fire;
      while (u < D && cyc < 1000) begin
         outReady = cyc[0];
         start    = (cyc == 5);             // must be ignored in UNLOAD
         chk("unload_outValid", outValid, 1);
         chk("unload_outData", outData, mem_m[u]);
         fire = outReady;
         tick();
         if (fire) u++;
         cyc++;
      end
      outReady = 1'b0; start = 1'b0;
      chk("unload_count", u, D);
      chk("unload_idle_busy", busy, 0);
      chk("unload_idle_outValid", outValid, 0);
      $display("unload transfers=%0d cycles=%0d", u, cyc);
   endtask

   initial begin
      // Reset values.
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_inReady", inReady, 0);
      chk("rst_outValid", outValid, 0);
      chk("rst_lineValid", lineValid, 0);
      chk("rst_line", line, 0);
      chk("rst_done", done, 0);
      rst = 1'b1;
      tick();
      $display("reset released");

      // Load, read 10 slices, then reset mid-SERVE with a read pending.
      do_load('0);
      for (int k = 0; k < 10; k++) begin
         readLine = 1'b1;
         exp_line = mem_m[k];
         tick();
         chk("pre_rst_lineValid", lineValid, 1);
         chk("pre_rst_line", line, exp_line);
      end
      rst = 1'b0;
      #1;
      chk("midrst_busy", busy, 0);
      chk("midrst_lineValid", lineValid, 0);
      chk("midrst_line", line, 0);
      exp_line = '0;
      tick();
      rst = 1'b1;
      readLine = 1'b0;
      tick();
      chk("postrst_busy", busy, 0);
      chk("postrst_lineValid", lineValid, 0);
      $display("mid-serve reset applied");

      // Run 1: pattern i, write-back ~i.
      do_load('0);
      do_serve(1'b0);
      do_unload();

      // Run 2: distinct pattern and random write-back data.
      do_load(25'h0AAAAAA);
      do_serve(1'b1);
      do_unload();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
